// File: rtl/exec_mem_stage_pkg.sv
// rtl/exec_mem_stage_pkg.sv - shared ALU op codes and default sizes for the execute/memory stage
package exec_mem_stage_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int RAM_WORDS_DEF = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } aluOp_t;

endpackage

// File: rtl/exec_mem_stage_if.sv
// rtl/exec_mem_stage_if.sv - valid/ready operation bus into and result bus out of the stage
interface exec_mem_stage_if #(
  parameter int DATA_W = exec_mem_stage_pkg::DATA_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic              dataIn_wE_BR;
  logic [3:0]        dataIn_OP_alu;
  logic              dataIn_SEL_dmx;
  logic              dataIn_W_ram;
  logic              dataIn_R_ram;
  logic [DATA_W-1:0] dataIn_DR1;
  logic [DATA_W-1:0] dataIn_DR2;

  logic              out_valid;
  logic              out_ready;
  logic              dataOut_wE_BR;
  logic [DATA_W-1:0] dataOut_WB;
  logic              dataOut_zero;
  logic              dataOut_ovf;
  logic [15:0]       dataOut_retired;

  modport master (
    output in_valid, dataIn_wE_BR, dataIn_OP_alu, dataIn_SEL_dmx, dataIn_W_ram,
           dataIn_R_ram, dataIn_DR1, dataIn_DR2, out_ready,
    input  in_ready, out_valid, dataOut_wE_BR, dataOut_WB, dataOut_zero,
           dataOut_ovf, dataOut_retired
  );

  modport slave (
    input  in_valid, dataIn_wE_BR, dataIn_OP_alu, dataIn_SEL_dmx, dataIn_W_ram,
           dataIn_R_ram, dataIn_DR1, dataIn_DR2, out_ready,
    output in_ready, out_valid, dataOut_wE_BR, dataOut_WB, dataOut_zero,
           dataOut_ovf, dataOut_retired
  );

endinterface

// File: rtl/alu32.sv
// rtl/alu32.sv - combinational ALU with zero flag and signed overflow for ADD/SUB
module alu32
  import exec_mem_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              ovf
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;

  assign sum  = A + B;
  assign diff = A - B;

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_AND: result = A & B;
      OP_OR:  result = A | B;
      OP_ADD: begin
        result = sum;
        ovf    = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
      end
      OP_XOR: result = A ^ B;
      OP_SLL: result = A << B[4:0];
      OP_SRL: result = A >> B[4:0];
      OP_SUB: begin
        result = diff;
        ovf    = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
      end
      OP_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_NOR: result = ~(A | B);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_mem_stage.sv
// rtl/exec_mem_stage.sv - single-entry execute/memory pipeline stage with ALU, data RAM and retire counter
module exec_mem_stage
  import exec_mem_stage_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RAM_WORDS = RAM_WORDS_DEF
) (
  input logic             clk,
  input logic             rst_n,
  exec_mem_stage_if.slave bus
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic              accept;
  logic              retire;
  logic [DATA_W-1:0] aluRes;
  logic              aluZero;
  logic              aluOvf;
  logic [AW-1:0]     ramAddr;
  logic [DATA_W-1:0] ramRd;

  logic              outValid;
  logic              wEReg;
  logic [DATA_W-1:0] wbReg;
  logic              zeroReg;
  logic              ovfReg;
  logic [15:0]       retiredReg;
  logic              unusedOk;

  alu32 #(.DATA_W(DATA_W)) u_alu (
    .A      (bus.dataIn_DR1),
    .B      (bus.dataIn_DR2),
    .op     (bus.dataIn_OP_alu),
    .result (aluRes),
    .zero   (aluZero),
    .ovf    (aluOvf)
  );

  assign bus.in_ready = !outValid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire       = outValid && bus.out_ready;

  // Byte address from the ALU, word-indexed; upper bits wrap.
  assign ramAddr = aluRes[AW+1:2];
  assign ramRd   = ram[ramAddr];

  // The load path samples ramRd before this edge's write lands, giving read-old.
  always_ff @(posedge clk) begin
    if (rst_n && accept && bus.dataIn_W_ram) begin
      ram[ramAddr] <= bus.dataIn_DR2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid   <= 1'b0;
      wEReg      <= 1'b0;
      wbReg      <= '0;
      zeroReg    <= 1'b0;
      ovfReg     <= 1'b0;
      retiredReg <= 16'd0;
    end else begin
      if (retire) begin
        retiredReg <= retiredReg + 16'd1;
      end
      if (accept) begin
        outValid <= 1'b1;
        wEReg    <= bus.dataIn_wE_BR;
        wbReg    <= bus.dataIn_SEL_dmx ? ramRd : aluRes;
        zeroReg  <= aluZero;
        ovfReg   <= aluOvf;
      end else if (retire) begin
        outValid <= 1'b0;
      end
    end
  end

  assign bus.out_valid       = outValid;
  assign bus.dataOut_wE_BR   = wEReg;
  assign bus.dataOut_WB      = wbReg;
  assign bus.dataOut_zero    = zeroReg;
  assign bus.dataOut_ovf     = ovfReg;
  assign bus.dataOut_retired = retiredReg;

  // RAM data is returned whenever SEL_dmx is set, so R_ram carries no function here.
  assign unusedOk = &{1'b0, bus.dataIn_R_ram};

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb/tb_exec_mem_stage.sv - randomized and directed bench for exec_mem_stage against a behavioural model
module tb_exec_mem_stage;

  logic clk;
  logic rst_n;
  logic started;
  int   errors;
  int   checks;

  exec_mem_stage_if #(.DATA_W(32)) bus ();

  exec_mem_stage #(.DATA_W(32), .RAM_WORDS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  // Behavioural model state
  logic        mValid;
  logic        mWE;
  logic [31:0] mWB;
  logic        mZero;
  logic        mOvf;
  logic [15:0] mRet;
  logic [31:0] mRam [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic ov);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    ov = 1'b0;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin s = sa + sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      4'd3:  r = a ^ b;
      4'd4:  r = a << b[4:0];
      4'd5:  r = a >> b[4:0];
      4'd6:  begin s = sa - sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: r = ~(a | b);
      default: r = 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic        acc;
    logic [31:0] r;
    logic        ov;
    logic [4:0]  addr;
    logic [31:0] rd;
    if (!rst_n) begin
      mValid = 1'b0;
      mWE    = 1'b0;
      mWB    = 32'd0;
      mZero  = 1'b0;
      mOvf   = 1'b0;
      mRet   = 16'd0;
    end else begin
      acc = bus.in_valid && (!mValid || bus.out_ready);
      if (mValid && bus.out_ready) mRet = mRet + 16'd1;
      if (acc) begin
        refAlu(bus.dataIn_OP_alu, bus.dataIn_DR1, bus.dataIn_DR2, r, ov);
        addr = r[6:2];
        rd   = mRam[addr];
        if (bus.dataIn_W_ram) mRam[addr] = bus.dataIn_DR2;
        mWB    = bus.dataIn_SEL_dmx ? rd : r;
        mZero  = (r == 32'd0);
        mOvf   = ov;
        mWE    = bus.dataIn_wE_BR;
        mValid = 1'b1;
      end else if (bus.out_ready) begin
        mValid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", bus.out_valid, mValid);
      chk("in_ready", bus.in_ready, !mValid || bus.out_ready);
      chk("retired", bus.dataOut_retired, mRet);
      chk("wE_BR", bus.dataOut_wE_BR, mWE);
      chk("WB", bus.dataOut_WB, mWB);
      chk("zero", bus.dataOut_zero, mZero);
      chk("ovf", bus.dataOut_ovf, mOvf);
    end
  end

  task automatic setIn(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic sel, input logic w, input logic r, input logic we);
    bus.in_valid       = v;
    bus.dataIn_OP_alu  = op;
    bus.dataIn_DR1     = a;
    bus.dataIn_DR2     = b;
    bus.dataIn_SEL_dmx = sel;
    bus.dataIn_W_ram   = w;
    bus.dataIn_R_ram   = r;
    bus.dataIn_wE_BR   = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [15:0] ret0;
    logic [31:0] d;
    errors        = 0;
    checks        = 0;
    started       = 1'b0;
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    setIn(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    #1 started = 1'b1;
    #2;
    chk("rst_out_valid", bus.out_valid, 32'd0);
    chk("rst_retired", bus.dataOut_retired, 32'd0);
    chk("rst_WB", bus.dataOut_WB, 32'd0);
    chk("rst_in_ready", bus.in_ready, 32'd1);

    tick();
    rst_n = 1'b1;
    #1 chk("rdy_after_rst", bus.in_ready, 32'd1);

    // Fill every RAM word with known data: ADD result lands on word i.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      d = $urandom;
      setIn(1, 4'd2, (i * 4) - d, d, 0, 1, 0, 0);
      tick();
    end

    setIn(1, 4'd2, 32'd5, 32'd7, 0, 0, 0, 1);
    tick();
    chk("add_valid", bus.out_valid, 32'd1);
    chk("add_WB", bus.dataOut_WB, 32'd12);
    chk("add_zero", bus.dataOut_zero, 32'd0);
    chk("add_ovf", bus.dataOut_ovf, 32'd0);

    setIn(1, 4'd2, 32'h7FFF_FFFF, 32'd1, 0, 0, 0, 0);
    tick();
    chk("ovf_WB", bus.dataOut_WB, 32'h8000_0000);
    chk("ovf_flag", bus.dataOut_ovf, 32'd1);

    setIn(1, 4'd6, 32'd9, 32'd9, 0, 0, 0, 0);
    tick();
    chk("sub_WB", bus.dataOut_WB, 32'd0);
    chk("sub_zero", bus.dataOut_zero, 32'd1);

    setIn(1, 4'd0, 32'd8, 32'hDEAD_BEEF, 0, 1, 0, 0);
    tick();
    chk("store_WB", bus.dataOut_WB, 32'd8);
    setIn(1, 4'd2, 32'd8, 32'd0, 1, 0, 1, 1);
    tick();
    chk("load_WB", bus.dataOut_WB, 32'hDEAD_BEEF);

    // Store then stall three cycles with a competing op presented
    setIn(1, 4'd0, 32'h0C, 32'hCAFE_F00D, 0, 1, 0, 0);
    tick();
    ret0 = mRet;
    bus.out_ready = 1'b0;
    setIn(1, 4'd2, 32'h0C, 32'h1111_1111, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", bus.out_valid, 32'd1);
      chk("stall_WB", bus.dataOut_WB, 32'h0C);
      chk("stall_in_ready", bus.in_ready, 32'd0);
      chk("stall_retired", bus.dataOut_retired, {16'd0, ret0});
    end
    setIn(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();
    chk("release_retired", bus.dataOut_retired, {16'd0, ret0 + 16'd1});
    chk("release_valid", bus.out_valid, 32'd0);
    setIn(1, 4'd2, 32'h0C, 32'd0, 1, 0, 1, 0);
    tick();
    chk("stall_load_WB", bus.dataOut_WB, 32'hCAFE_F00D);

    // Reset asserted mid-stall with a store waiting upstream
    setIn(1, 4'd2, 32'd1, 32'd1, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    tick();
    setIn(1, 4'd0, 32'd8, 32'h1234_5678, 0, 1, 0, 0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.out_valid, 32'd0);
    chk("midrst_retired", bus.dataOut_retired, 32'd0);
    chk("midrst_in_ready", bus.in_ready, 32'd1);
    tick();
    rst_n = 1'b1;
    setIn(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    tick();

    // Four back-to-back ops, the first two confirming RAM survived reset
    setIn(1, 4'd2, 32'd8, 32'd0, 1, 0, 1, 0);
    tick();
    chk("b2b0_valid", bus.out_valid, 32'd1);
    chk("b2b0_WB", bus.dataOut_WB, 32'hDEAD_BEEF);
    setIn(1, 4'd2, 32'h0C, 32'd0, 1, 0, 1, 0);
    tick();
    chk("b2b1_valid", bus.out_valid, 32'd1);
    chk("b2b1_WB", bus.dataOut_WB, 32'hCAFE_F00D);
    setIn(1, 4'd2, 32'd1, 32'd2, 0, 0, 0, 1);
    tick();
    chk("b2b2_valid", bus.out_valid, 32'd1);
    chk("b2b2_WB", bus.dataOut_WB, 32'd3);
    setIn(1, 4'd3, 32'hF0, 32'hFF, 0, 0, 0, 0);
    tick();
    chk("b2b3_valid", bus.out_valid, 32'd1);
    chk("b2b3_WB", bus.dataOut_WB, 32'h0F);
    setIn(0, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    tick();
    chk("b2b_retired", bus.dataOut_retired, 32'd4);
    chk("b2b_drained", bus.out_valid, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      setIn($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pickOperand(), pickOperand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end

    // Retire counter wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    setIn(1, 4'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    repeat (65536) @(posedge clk);
    #1 chk("retired_max", bus.dataOut_retired, 32'h0000_FFFF);
    tick();
    chk("retired_wrap", bus.dataOut_retired, 32'd0);
    chk("wrap_valid", bus.out_valid, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
